// File: rtl/sopc_run_ctrl.sv
// SOPC run controller: staggered per-channel reset release, then a counted run phase.
// Define SOPC_RUN_TIMEOUT_EN to end the run in DONE once cycle_cnt reaches RUN_CYCLES.
module sopc_run_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 1,
    parameter int RUN_CYCLES  = 50,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rerun,
    input  logic                hold_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                running,
    output logic                done,
    output logic [CNT_W-1:0]    cycle_cnt
);

    localparam int LAST = HOLD_CYCLES + (CHANNELS - 1) * STAGGER;
    localparam int TW   = $clog2(LAST + 1);

`ifdef SOPC_RUN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        rst_out_d = rst_out_q;
        running_d = running_q;
        done_d    = done_q;
        cyc_d     = cyc_q;

        case (state_q)
            ST_HOLD, ST_RELEASE: begin
                tmr_d = tmr_q + TW'(1);
                // Timer only rises, so each channel drops once, in index order.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (int'(tmr_d) >= HOLD_CYCLES + i * STAGGER) begin
                        rst_out_d[i] = 1'b0;
                    end
                end
                if (int'(tmr_d) == LAST) begin
                    state_d   = ST_RUN;
                    running_d = 1'b1;
                end else if (int'(tmr_d) >= HOLD_CYCLES) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RUN: begin
                if (!hold_req && cyc_q != CNT_MAX) begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
                if (TIMEOUT_EN && int'(cyc_d) == RUN_CYCLES) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (rerun) begin
            state_d   = ST_HOLD;
            tmr_d     = '0;
            rst_out_d = '1;
            running_d = 1'b0;
            done_d    = 1'b0;
            cyc_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            tmr_q     <= '0;
            rst_out_q <= '1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            rst_out_q <= rst_out_d;
            running_q <= running_d;
            done_q    <= done_d;
            cyc_q     <= cyc_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign running   = running_q;
    assign done      = TIMEOUT_EN ? done_q : 1'b0;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl: default instance plus a 3-channel,
// stagger-2, 4-bit-counter instance for release order and saturation.
module tb_sopc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, rerun, hold_req;
    logic [1:0]  rst_out;
    logic        running, done;
    logic [15:0] cycle_cnt;

    logic        rst2, rerun2, hold_req2;
    logic [2:0]  rst_out2;
    logic        running2, done2;
    logic [3:0]  cycle_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sopc_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rerun     (rerun),
        .hold_req  (hold_req),
        .rst_out   (rst_out),
        .running   (running),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    sopc_run_ctrl #(
        .CHANNELS    (3),
        .HOLD_CYCLES (4),
        .STAGGER     (2),
        .RUN_CYCLES  (100),
        .CNT_W       (4)
    ) dut2 (
        .clk       (clk),
        .rst       (rst2),
        .rerun     (rerun2),
        .hold_req  (hold_req2),
        .rst_out   (rst_out2),
        .running   (running2),
        .done      (done2),
        .cycle_cnt (cycle_cnt2)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rerun = 1'b0; hold_req = 1'b0;
        tick(3);
        checks++;
        if ({rst_out, running, done, cycle_cnt} !== {2'b11, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: got rst_out=%b run=%b done=%b cnt=%0d want 11 0 0 0",
                     rst_out, running, done, cycle_cnt);
        end
        rst = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            logic [1:0] exp_ro;
            logic       exp_run;
            tick();
            exp_ro  = (e <= 9) ? 2'b11 : (e == 10) ? 2'b10 : 2'b00;
            exp_run = (e == 11);
            checks++;
            if (rst_out !== exp_ro || running !== exp_run || cycle_cnt !== 16'd0) begin
                errors++;
                $display("FAIL release_edge%0d: got rst_out=%b run=%b cnt=%0d want %b %b 0",
                         e, rst_out, running, cycle_cnt, exp_ro, exp_run);
            end
        end
    endtask

    task automatic test_run_hold();
        tick(20);
        checks++;
        if (cycle_cnt !== 16'd20 || running !== 1'b1) begin
            errors++;
            $display("FAIL run_count20: got cnt=%0d run=%b want 20 1", cycle_cnt, running);
        end
        hold_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cycle_cnt !== 16'd20) begin
                errors++;
                $display("FAIL hold_flat%0d: got cnt=%0d want 20", i, cycle_cnt);
            end
        end
        hold_req = 1'b0;
        tick(29);
        checks++;
        if (cycle_cnt !== 16'd49 || running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL edge65: got cnt=%0d run=%b done=%b want 49 1 0",
                     cycle_cnt, running, done);
        end
        tick();
`ifdef SOPC_RUN_TIMEOUT_EN
        checks++;
        if ({rst_out, running, done, cycle_cnt} !== {2'b00, 1'b0, 1'b1, 16'd50}) begin
            errors++;
            $display("FAIL done_edge66: got ro=%b run=%b done=%b cnt=%0d want 00 0 1 50",
                     rst_out, running, done, cycle_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            hold_req = i[0];
            tick();
            checks++;
            if ({rst_out, running, done, cycle_cnt} !== {2'b00, 1'b0, 1'b1, 16'd50}) begin
                errors++;
                $display("FAIL done_frozen%0d: got ro=%b run=%b done=%b cnt=%0d want 00 0 1 50",
                         i, rst_out, running, done, cycle_cnt);
            end
        end
        hold_req = 1'b0;
`else
        checks++;
        if (cycle_cnt !== 16'd50 || running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout66: got cnt=%0d run=%b done=%b want 50 1 0",
                     cycle_cnt, running, done);
        end
        tick(20);
        checks++;
        if (cycle_cnt !== 16'd70 || running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout86: got cnt=%0d run=%b done=%b want 70 1 0",
                     cycle_cnt, running, done);
        end
`endif
    endtask

    task automatic test_rerun_vs_hold();
        rerun = 1'b1; hold_req = 1'b1;
        tick();
        rerun = 1'b0; hold_req = 1'b0;
        checks++;
        if ({rst_out, running, done, cycle_cnt} !== {2'b11, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL rerun_restart: got ro=%b run=%b done=%b cnt=%0d want 11 0 0 0",
                     rst_out, running, done, cycle_cnt);
        end
        tick(31);
        checks++;
        if (cycle_cnt !== 16'd20 || rst_out !== 2'b00 || running !== 1'b1) begin
            errors++;
            $display("FAIL rerun_cnt20: got cnt=%0d ro=%b run=%b want 20 00 1",
                     cycle_cnt, rst_out, running);
        end
        rerun = 1'b1; hold_req = 1'b1;
        tick();
        rerun = 1'b0; hold_req = 1'b0;
        checks++;
        if ({rst_out, running, cycle_cnt} !== {2'b11, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL rerun_wins: got ro=%b run=%b cnt=%0d want 11 0 0",
                     rst_out, running, cycle_cnt);
        end
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e >= 9) begin
                logic [1:0] exp_ro;
                exp_ro = (e == 9) ? 2'b11 : (e == 10) ? 2'b10 : 2'b00;
                checks++;
                if (rst_out !== exp_ro || running !== (e == 11)) begin
                    errors++;
                    $display("FAIL rerun_seq_edge%0d: got ro=%b run=%b want %b %b",
                             e, rst_out, running, exp_ro, (e == 11));
                end
            end
        end
    endtask

    task automatic test_rerun_held();
        rerun = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (rst_out !== 2'b11 || cycle_cnt !== 16'd0 || running !== 1'b0) begin
                errors++;
                $display("FAIL rerun_held%0d: got ro=%b cnt=%0d run=%b want 11 0 0",
                         i, rst_out, cycle_cnt, running);
            end
        end
        rerun = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e >= 10) begin
                logic [1:0] exp_ro;
                exp_ro = (e == 10) ? 2'b10 : 2'b00;
                checks++;
                if (rst_out !== exp_ro) begin
                    errors++;
                    $display("FAIL held_release_edge%0d: got ro=%b want %b", e, rst_out, exp_ro);
                end
            end
        end
    endtask

    task automatic test_rst_mid_release();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(10);
        checks++;
        if (rst_out !== 2'b10 || running !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got ro=%b run=%b want 10 0", rst_out, running);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rst_out !== 2'b11 || running !== 1'b0 || cycle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_release: got ro=%b run=%b cnt=%0d want 11 0 0",
                     rst_out, running, cycle_cnt);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e >= 9) begin
                logic [1:0] exp_ro;
                exp_ro = (e == 9) ? 2'b11 : 2'b10;
                checks++;
                if (rst_out !== exp_ro) begin
                    errors++;
                    $display("FAIL recount_edge%0d: got ro=%b want %b", e, rst_out, exp_ro);
                end
            end
        end
    endtask

    task automatic test_stagger_saturate();
        rst2 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            logic [2:0] exp_ro;
            logic [3:0] exp_cnt;
            logic       exp_run;
            tick();
            exp_ro  = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 : (e < 8) ? 3'b100 : 3'b000;
            exp_run = (e >= 8);
            exp_cnt = (e <= 8) ? 4'd0 : (e >= 23) ? 4'd15 : 4'(e - 8);
            if (e == 3 || e == 4 || e == 6 || e == 7 || e == 8 ||
                e == 22 || e == 23 || e == 40) begin
                checks++;
                if (rst_out2 !== exp_ro || running2 !== exp_run ||
                    cycle_cnt2 !== exp_cnt || done2 !== 1'b0) begin
                    errors++;
                    $display("FAIL stagger_sat_edge%0d: got ro=%b run=%b cnt=%0d done=%b want %b %b %0d 0",
                             e, rst_out2, running2, cycle_cnt2, done2, exp_ro, exp_run, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        rst2 = 1'b1; rerun2 = 1'b0; hold_req2 = 1'b0;
        test_reset();
        test_run_hold();
        test_rerun_vs_hold();
        test_rerun_held();
        test_rst_mid_release();
        test_stagger_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sopc_run_ctrl.md
SOPC_RUN_CTRL -- requirements
Module: sopc_run_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent reset outputs (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 10: cycles all outputs stay in reset after rst deasserts (>=1).
REQ-003 SHALL have parameter STAGGER, default 1: cycles between successive channel releases (0 = all release together).
REQ-004 SHALL have parameter RUN_CYCLES, default 50: run budget in counted cycles (>=1).
REQ-005 SHALL have parameter CNT_W, default 16: width of cycle counter.
REQ-006 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-008 SHALL have port rerun  input  1: one-cycle pulse restarting the whole sequence.
REQ-009 SHALL have port hold_req  input  1: pauses run counting while high.
REQ-010 SHALL have port rst_out  output  CHANNELS: per-channel reset to the SOPC, active-high (RstEnable = 1).
REQ-011 SHALL have port running  output  1: high in RUN state.
REQ-012 SHALL have port done  output  1: sticky run-complete flag.
REQ-013 SHALL have port cycle_cnt  output  CNT_W: counted run cycles.

Function
REQ-014 SHALL implement FSM states HOLD, RELEASE, RUN, DONE; all outputs registered.
REQ-015 HOLD: all rst_out=1; internal counter increments each edge; edge number HOLD_CYCLES (edge 1 = first edge with rst=0) enters RELEASE and clears rst_out[0] on that same edge.
REQ-016 RELEASE: rst_out[i] clears on edge HOLD_CYCLES + i*STAGGER; once cleared stays cleared until HOLD re-entered; channels clear in ascending index order only.
REQ-017 The edge clearing rst_out[CHANNELS-1] SHALL enter RUN; running=1 from that edge; with STAGGER=0 or CHANNELS=1, HOLD goes straight to RUN.
REQ-018 RUN: cycle_cnt increments by 1 on each edge with hold_req=0; holds value when hold_req=1.
REQ-019 cycle_cnt SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 rerun=1 in any state SHALL on that edge enter HOLD: rst_out all 1, running=0, done=0, cycle_cnt=0, internal counter=0.
REQ-021 rerun and hold_req high on the same edge: rerun wins.
REQ-022 DONE: rst_out stays all 0, running=0, done=1, cycle_cnt frozen; only rerun or rst leaves DONE.
REQ-023 rerun held high for multiple cycles SHALL keep the block in HOLD with counter at 0.

Reset
REQ-024 rst=1 on an edge SHALL force state HOLD, rst_out all 1, running=0, done=0, cycle_cnt=0, internal counter=0, regardless of state (including mid-RELEASE or mid-RUN).
REQ-025 rst SHALL take priority over rerun and hold_req.

Configuration
REQ-026 Macro SOPC_RUN_TIMEOUT_EN defined: edge on which cycle_cnt becomes RUN_CYCLES SHALL enter DONE and set done=1.
REQ-027 Macro SOPC_RUN_TIMEOUT_EN undefined: RUN never exits except via rst/rerun; done tied 0; DONE state unreachable; cycle_cnt saturates per REQ-019.

Verification
REQ-028 Defaults, rst high 3 cycles then low -> rst_out=2'b11 for edges 1..9, 2'b10 at edge 10, 2'b00 and running=1 at edge 11.
REQ-029 Defaults with SOPC_RUN_TIMEOUT_EN, no hold_req -> done=1, running=0, cycle_cnt=50 at edge 61; values frozen 20 further cycles.
REQ-030 hold_req high 5 cycles mid-RUN -> cycle_cnt flat during those 5 edges; done delayed to edge 66.
REQ-031 rerun pulse at cycle_cnt=20 with hold_req=1 same edge -> next state HOLD, rst_out=2'b11, cycle_cnt=0; sequence repeats per REQ-028 timing relative to pulse.
REQ-032 rst pulse mid-RELEASE (rst_out=2'b10) -> rst_out=2'b11, running=0 next edge; full hold re-counted.
REQ-033 CNT_W=4, RUN_CYCLES=100, macro undefined -> cycle_cnt saturates at 15, done stays 0, running stays 1.
